// File: rtl/iir_ctrl_pkg.sv
// Shared types and constants for the IIR coefficient controller: FSM states,
// shadow-register address map, power-up coefficient set and the write decoder.
`timescale 1ns/1ps
package iir_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PENDING = 2'd1,
    FLUSH   = 2'd2
  } state_t;

  localparam logic [3:0] ADDR_CX_L  = 4'd0;
  localparam logic [3:0] ADDR_CX_M  = 4'd1;
  localparam logic [3:0] ADDR_CX_H  = 4'd2;
  localparam logic [3:0] ADDR_CX0   = 4'd3;
  localparam logic [3:0] ADDR_CX1   = 4'd4;
  localparam logic [3:0] ADDR_CX2   = 4'd5;
  localparam logic [3:0] ADDR_CY0_L = 4'd6;
  localparam logic [3:0] ADDR_CY0_H = 4'd7;
  localparam logic [3:0] ADDR_CY1_L = 4'd8;
  localparam logic [3:0] ADDR_CY1_H = 4'd9;
  localparam logic [3:0] ADDR_CY2_L = 4'd10;
  localparam logic [3:0] ADDR_CY2_H = 4'd11;

  // Power-up set: a gentle low-pass so the filter is usable before any commit.
  localparam logic [39:0] DEF_CX  = 40'h00_0100_0000;
  localparam logic [7:0]  DEF_CX0 = 8'h10;
  localparam logic [7:0]  DEF_CX1 = 8'h20;
  localparam logic [7:0]  DEF_CX2 = 8'h10;
  localparam logic [23:0] DEF_CY0 = 24'h40_0000;
  localparam logic [23:0] DEF_CY1 = 24'h9A_5C3E;
  localparam logic [23:0] DEF_CY2 = 24'h2C_81F7;

  typedef struct packed {
    logic [39:0] cx;
    logic [7:0]  cx0;
    logic [7:0]  cx1;
    logic [7:0]  cx2;
    logic [23:0] cy0;
    logic [23:0] cy1;
    logic [23:0] cy2;
  } coeff_set_t;

  localparam coeff_set_t DEF_SET = '{
    cx:  DEF_CX,
    cx0: DEF_CX0,
    cx1: DEF_CX1,
    cx2: DEF_CX2,
    cy0: DEF_CY0,
    cy1: DEF_CY1,
    cy2: DEF_CY2
  };

  // Merges one 16-bit config word into a coefficient set; unmapped addresses leave it untouched.
  function automatic coeff_set_t coeff_write(input coeff_set_t s,
                                             input logic [3:0] addr,
                                             input logic [15:0] data);
    coeff_set_t r;
    r = s;
    case (addr)
      ADDR_CX_L:  r.cx[15:0]  = data;
      ADDR_CX_M:  r.cx[31:16] = data;
      ADDR_CX_H:  r.cx[39:32] = data[7:0];
      ADDR_CX0:   r.cx0       = data[7:0];
      ADDR_CX1:   r.cx1       = data[7:0];
      ADDR_CX2:   r.cx2       = data[7:0];
      ADDR_CY0_L: r.cy0[15:0] = data;
      ADDR_CY0_H: r.cy0[23:16] = data[7:0];
      ADDR_CY1_L: r.cy1[15:0] = data;
      ADDR_CY1_H: r.cy1[23:16] = data[7:0];
      ADDR_CY2_L: r.cy2[15:0] = data;
      ADDR_CY2_H: r.cy2[23:16] = data[7:0];
      default:    r = s;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/iir_ce_gen.sv
// Free-running clock-enable generator: ce every CE_DIV clocks, sample_ce on every
// second ce (the filter runs at twice the output sample rate).
`timescale 1ns/1ps
module iir_ce_gen #(
  parameter int CE_DIV = 500
) (
  input  logic clk,
  input  logic reset,
  output logic ce,
  output logic sample_ce
);

  localparam int CW = (CE_DIV <= 2) ? 1 : $clog2(CE_DIV);
  localparam logic [CW-1:0] CNT_LAST = CW'(CE_DIV - 1);

  logic [CW-1:0] r_cnt;
  logic          r_phase;
  logic          w_ce;

  assign w_ce = (r_cnt == CNT_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt   <= '0;
      r_phase <= 1'b0;
    end else if (w_ce) begin
      r_cnt   <= '0;
      r_phase <= ~r_phase;
    end else begin
      r_cnt   <= r_cnt + CW'(1);
    end
  end

  assign ce        = w_ce;
  assign sample_ce = w_ce & r_phase;

endmodule

// File: rtl/iir_coeff_ctrl.sv
// IIR coefficient controller: shadow register file, commit FSM applying the set
// atomically on sample_ce. Optional post-apply tap flush under IIR_CTRL_FLUSH_EN.
`timescale 1ns/1ps
module iir_coeff_ctrl
  import iir_ctrl_pkg::*;
#(
  parameter int CE_DIV = 500
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cfg_wr,
  input  logic [3:0]  cfg_addr,
  input  logic [15:0] cfg_data,
  input  logic        cfg_commit,
  output logic        cfg_ready,
  output logic        cfg_done,
  output logic        ce,
  output logic        sample_ce,
  output logic [39:0] cx,
  output logic [7:0]  cx0,
  output logic [7:0]  cx1,
  output logic [7:0]  cx2,
  output logic [23:0] cy0,
  output logic [23:0] cy1,
  output logic [23:0] cy2,
  output logic        filt_reset
);

  logic       w_ce;
  logic       w_sample_ce;
  coeff_set_t r_shadow;
  coeff_set_t r_active;
  state_t     r_state;
  logic       r_cfg_ready;
  logic       r_cfg_done;

  iir_ce_gen #(
    .CE_DIV    (CE_DIV)
  ) u_ce_gen (
    .clk       (clk),
    .reset     (reset),
    .ce        (w_ce),
    .sample_ce (w_sample_ce)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_shadow <= DEF_SET;
    end else if (cfg_wr && r_cfg_ready) begin
      r_shadow <= coeff_write(r_shadow, cfg_addr, cfg_data);
    end
  end

`ifdef IIR_CTRL_FLUSH_EN
  localparam logic [16:0] FLUSH_LAST = 17'(2 * CE_DIV - 1);

  logic [16:0] r_flush_cnt;
  logic        r_filt_reset;

  // Commit FSM with tap flush; the flush down-counter covers two full ce periods.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= IDLE;
      r_cfg_ready  <= 1'b1;
      r_cfg_done   <= 1'b0;
      r_active     <= DEF_SET;
      r_filt_reset <= 1'b0;
      r_flush_cnt  <= '0;
    end else begin
      r_cfg_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (cfg_commit) begin
            r_state     <= PENDING;
            r_cfg_ready <= 1'b0;
          end
        end
        PENDING: begin
          if (w_sample_ce) begin
            r_active     <= r_shadow;
            r_state      <= FLUSH;
            r_filt_reset <= 1'b1;
            r_flush_cnt  <= FLUSH_LAST;
          end
        end
        FLUSH: begin
          if (r_flush_cnt == '0) begin
            r_filt_reset <= 1'b0;
            r_cfg_done   <= 1'b1;
            r_cfg_ready  <= 1'b1;
            r_state      <= IDLE;
          end else begin
            r_flush_cnt <= r_flush_cnt - 17'd1;
          end
        end
        default: begin
          r_state      <= IDLE;
          r_cfg_ready  <= 1'b1;
          r_filt_reset <= 1'b0;
        end
      endcase
    end
  end

  assign filt_reset = r_filt_reset;
`else
  // Commit FSM without flush: apply returns straight to IDLE and signals done.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_cfg_ready <= 1'b1;
      r_cfg_done  <= 1'b0;
      r_active    <= DEF_SET;
    end else begin
      r_cfg_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (cfg_commit) begin
            r_state     <= PENDING;
            r_cfg_ready <= 1'b0;
          end
        end
        PENDING: begin
          if (w_sample_ce) begin
            r_active    <= r_shadow;
            r_state     <= IDLE;
            r_cfg_ready <= 1'b1;
            r_cfg_done  <= 1'b1;
          end
        end
        default: begin
          r_state     <= IDLE;
          r_cfg_ready <= 1'b1;
        end
      endcase
    end
  end

  assign filt_reset = 1'b0;
`endif

  assign cfg_ready = r_cfg_ready;
  assign cfg_done  = r_cfg_done;
  assign ce        = w_ce;
  assign sample_ce = w_sample_ce;
  assign cx        = r_active.cx;
  assign cx0       = r_active.cx0;
  assign cx1       = r_active.cx1;
  assign cx2       = r_active.cx2;
  assign cy0       = r_active.cy0;
  assign cy1       = r_active.cy1;
  assign cy2       = r_active.cy2;

endmodule
